// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer and its operand datapath.
package calc_pkg;

  // Sequencer state codes, common to the sequencer and the datapath.
  typedef enum logic [1:0] {
    WAIT_OP1    = 2'd0,
    WAIT_OP2    = 2'd1,
    WAIT_OP     = 2'd2,
    SHOW_RESULT = 2'd3
  } state_e;

  // ALU opcodes as taken from data_in[1:0].
  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } opcode_e;

  // Bit positions inside the 4-bit {N, Z, C, V} flag vector.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU: ADD/SUB/AND/OR with {N, Z, C, V} flags.
module calc_alu
  import calc_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] res,
  output logic [3:0]   flags
);

  logic [W:0] sum_ext;
  logic [W:0] diff_ext;
  logic       carry;
  logic       ovf;

  // Extra top bit gives carry-out for ADD and borrow for SUB.
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  // Select result and carry/overflow per opcode, then derive N and Z from the result.
  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    unique case (opcode_e'(op))
      ADD: begin
        res   = sum_ext[W-1:0];
        carry = sum_ext[W];
        ovf   = (a[W-1] == b[W-1]) && (sum_ext[W-1] != a[W-1]);
      end
      SUB: begin
        res   = diff_ext[W-1:0];
        carry = ~diff_ext[W];  // no-borrow: a >= b unsigned
        ovf   = (a[W-1] != b[W-1]) && (diff_ext[W-1] != a[W-1]);
      end
      AND: res = a & b;
      OR:  res = a | b;
    endcase
    flags         = '0;
    flags[FLAG_N] = res[W-1];
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/calc_operand_datapath.sv
// Operand capture, one-cycle compute, display mux and state-sequence monitor
// for the four-state calculator sequencer.
module calc_operand_datapath
  import calc_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         trans,
  input  logic [1:0]   estado,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] display_val,
  output logic         result_valid,
  output logic [3:0]   flags,
  output logic         seq_error
);

  state_e       state_s;
  logic [W-1:0] op1_q;
  logic [W-1:0] op2_q;
  logic [1:0]   opcode_q;
  logic [W-1:0] res_q;
  logic [3:0]   flags_q;
  logic         result_valid_q;
  logic         busy_q;
  logic [W-1:0] display_q;
  logic         seq_error_q;
  logic [1:0]   prev_estado_q;
  logic         trans_prev_q;
  logic [W-1:0] alu_res;
  logic [3:0]   alu_flags;
  logic [1:0]   next_code;
  logic         seq_bad;

  assign state_s = state_e'(estado);

  calc_alu #(
    .W(W)
  ) u_alu (
    .a    (op1_q),
    .b    (op2_q),
    .op   (opcode_q),
    .res  (alu_res),
    .flags(alu_flags)
  );

  // Operand/opcode capture and result load; a clear on the same edge as the compute wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q          <= '0;
      op2_q          <= '0;
      opcode_q       <= '0;
      res_q          <= '0;
      flags_q        <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      if (busy_q) begin
        res_q          <= alu_res;
        flags_q        <= alu_flags;
        result_valid_q <= 1'b1;
        busy_q         <= 1'b0;
      end
      if (trans) begin
        unique case (state_s)
          WAIT_OP1: begin
            op1_q          <= data_in;
            res_q          <= '0;
            flags_q        <= '0;
            result_valid_q <= 1'b0;
          end
          WAIT_OP2: op2_q <= data_in;
          WAIT_OP: begin
            opcode_q <= data_in[1:0];
            busy_q   <= 1'b1;
          end
          SHOW_RESULT: result_valid_q <= 1'b0;
        endcase
      end
    end
  end

  // Registered display source selected by the current state code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display_q <= '0;
    end else begin
      unique case (state_s)
        WAIT_OP1, WAIT_OP2: display_q <= data_in;
        WAIT_OP:            display_q <= {{(W-2){1'b0}}, data_in[1:0]};
        SHOW_RESULT:        display_q <= res_q;
      endcase
    end
  end

  // A state change is legal only as a +1 (mod 4) step following a trans pulse.
  always_comb begin
    next_code = prev_estado_q + 2'd1;
    seq_bad   = (estado != prev_estado_q) && ((estado != next_code) || !trans_prev_q);
  end

  // Sticky sequence monitor; history registers track the previous cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_error_q   <= 1'b0;
      prev_estado_q <= 2'd0;
      trans_prev_q  <= 1'b0;
    end else begin
      prev_estado_q <= estado;
      trans_prev_q  <= trans;
      if (seq_bad) begin
        seq_error_q <= 1'b1;
      end
    end
  end

  assign display_val  = display_q;
  assign result_valid = result_valid_q;
  assign flags        = flags_q;
  assign seq_error    = seq_error_q;

endmodule

// File: tb/tb_calc_operand_datapath.sv
// Scoreboard bench for calc_operand_datapath: the driver pushes expected results,
// a monitor pops them whenever result_valid rises.
module tb_calc_operand_datapath;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic         trans;
  logic [1:0]   estado;
  logic [W-1:0] data_in;
  logic [W-1:0] display_val;
  logic         result_valid;
  logic [3:0]   flags;
  logic         seq_error;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  calc_operand_datapath #(
    .W(W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trans       (trans),
    .estado      (estado),
    .data_in     (data_in),
    .display_val (display_val),
    .result_valid(result_valid),
    .flags       (flags),
    .seq_error   (seq_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model in plain integer arithmetic.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [1:0] op);
    exp_t e;
    int   ua, ub, sa, sb, r, s;
    bit   c, v;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    c  = 0;
    v  = 0;
    r  = 0;
    case (op)
      2'd0: begin
        r = ua + ub;
        c = (r > 65535);
        s = sa + sb;
        v = (s > 32767) || (s < -32768);
      end
      2'd1: begin
        r = ua - ub;
        c = (ua >= ub);
        s = sa - sb;
        v = (s > 32767) || (s < -32768);
      end
      2'd2: r = ua & ub;
      default: r = ua | ub;
    endcase
    e.res = r[15:0];
    e.flg = {e.res[15], (e.res == 16'd0), c, v};
    return e;
  endfunction

  task automatic step(input logic [1:0] st, input logic [15:0] d, input logic tr);
    @(negedge clk);
    estado  = st;
    data_in = d;
    trans   = tr;
    @(posedge clk);
    #1;
  endtask

  // Full legal pass: capture op1, op2, opcode, show, then clear on trans in show_result.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                        input exp_t e);
    logic [15:0] opw;
    opw = {$urandom_range(0, 16383)} [13:0] == 14'd0 ? {14'd0, op} : {14'h1555, op};
    step(2'd0, a, 1'b1);
    check("clr_valid", {31'd0, result_valid}, 32'd0);
    check("clr_flags", {28'd0, flags}, 32'd0);
    check("disp_op1", {16'd0, display_val}, {16'd0, a});
    check("seq_ok", {31'd0, seq_error}, 32'd0);
    step(2'd1, b, 1'b1);
    check("disp_op2", {16'd0, display_val}, {16'd0, b});
    exp_q.push_back(e);
    step(2'd2, opw, 1'b1);
    check("disp_opc", {16'd0, display_val}, {30'd0, op});
    check("busy_no_valid", {31'd0, result_valid}, 32'd0);
    step(2'd3, 16'($urandom), 1'b0);
    step(2'd3, 16'($urandom), 1'b0);
    step(2'd3, 16'($urandom), 1'b1);
    check("clr_on_show", {31'd0, result_valid}, 32'd0);
  endtask

  task automatic run_const(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                           input logic [15:0] r, input logic [3:0] f);
    exp_t e;
    e.res = r;
    e.flg = f;
    run_op(a, b, op, e);
  endtask

  // Monitor: on each rising result_valid pop one expectation; the display shows it an edge later.
  initial begin
    logic prev_rv;
    exp_t e;
    prev_rv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_rv = 1'b0;
      end else begin
        if (result_valid && !prev_rv) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", {31'd0, result_valid}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("flags", {28'd0, flags}, {28'd0, e.flg});
            @(posedge clk);
            #1;
            check("result", {16'd0, display_val}, {16'd0, e.res});
          end
        end
        prev_rv = result_valid;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b;
    logic [1:0]  op;
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    trans   = 1'b0;
    estado  = 2'd0;
    data_in = 16'h1234;
    repeat (2) @(posedge clk);
    #1;
    check("rst_disp", {16'd0, display_val}, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);
    check("rst_seq", {31'd0, seq_error}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed arithmetic corners.
    run_const(16'h0005, 16'h0003, 2'd0, 16'h0008, 4'b0000);
    run_const(16'h0003, 16'h0005, 2'd1, 16'hFFFE, 4'b1000);
    run_const(16'h7FFF, 16'h0001, 2'd0, 16'h8000, 4'b1001);
    run_const(16'hFFFF, 16'h0001, 2'd0, 16'h0000, 4'b0110);
    run_const(16'h1234, 16'h1234, 2'd1, 16'h0000, 4'b0110);
    run_const(16'h8000, 16'h0001, 2'd1, 16'h7FFF, 4'b0011);
    run_const(16'hF0F0, 16'hFF00, 2'd2, 16'hF000, 4'b1000);
    run_const(16'h00F0, 16'h0F00, 2'd3, 16'h0FF0, 4'b0000);

    // Randomized operations against the model.
    for (int i = 0; i < 25; i++) begin
      a  = 16'($urandom);
      b  = (i % 5 == 0) ? a : 16'($urandom);
      op = 2'($urandom_range(0, 3));
      run_op(a, b, op, model(a, b, op));
    end

    // Back-to-back: trans in show_result on the compute edge; the clear wins.
    step(2'd0, 16'h0011, 1'b1);
    step(2'd1, 16'h0022, 1'b1);
    step(2'd2, 16'h0000, 1'b1);
    step(2'd3, 16'h0000, 1'b1);
    check("b2b_clear_wins", {31'd0, result_valid}, 32'd0);
    step(2'd0, 16'h0000, 1'b0);
    check("b2b_still_clear", {31'd0, result_valid}, 32'd0);
    check("b2b_seq_ok", {31'd0, seq_error}, 32'd0);

    // Illegal jump 0 -> 2 is sticky through later legal steps.
    step(2'd2, 16'h0000, 1'b0);
    check("seq_jump", {31'd0, seq_error}, 32'd1);
    step(2'd2, 16'h0000, 1'b1);
    step(2'd3, 16'h0000, 1'b1);
    step(2'd0, 16'h0000, 1'b0);
    check("seq_sticky", {31'd0, seq_error}, 32'd1);
    @(negedge clk);
    rst    = 1'b1;
    estado = 2'd0;
    trans  = 1'b0;
    #1;
    check("seq_rst", {31'd0, seq_error}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Legal +1 step but without a preceding trans.
    step(2'd0, 16'h0000, 1'b0);
    step(2'd1, 16'h0000, 1'b0);
    check("seq_no_trans", {31'd0, seq_error}, 32'd1);
    @(negedge clk);
    rst    = 1'b1;
    estado = 2'd0;
    @(negedge clk);
    rst = 1'b0;

    // Async reset between opcode capture and the compute edge.
    step(2'd0, 16'h0005, 1'b1);
    step(2'd1, 16'h0003, 1'b1);
    step(2'd2, 16'h0001, 1'b1);
    check("pre_rst_disp", {16'd0, display_val}, 32'd1);
    @(negedge clk);
    estado = 2'd0;
    trans  = 1'b0;
    rst    = 1'b1;
    #1;
    check("async_disp", {16'd0, display_val}, 32'd0);
    check("async_valid", {31'd0, result_valid}, 32'd0);
    check("async_flags", {28'd0, flags}, 32'd0);
    check("async_seq", {31'd0, seq_error}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(2'd0, 16'h0000, 1'b0);
      check("no_result_after_rst", {31'd0, result_valid}, 32'd0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_operand_datapath.md
# calc_operand_datapath

Datapath that follows the four-state calculator sequencer (wait_op1 → wait_op2 → wait_op → show_result). On each `trans` pulse it captures switch data into the slot selected by the sequencer's current state code, computes the result one cycle after the opcode is taken, and drives the value to show on the display. It also monitors the state code for illegal sequences. It sits between the switch/button front end and the display driver.

## Interface
- `W`, default 16: operand and result width.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `trans` input 1: single-cycle advance pulse, the same pulse that steps the sequencer.
- `estado` input 2: sequencer state code.
  - 0 = wait_op1
  - 1 = wait_op2
  - 2 = wait_op
  - 3 = show_result
- `data_in` input W: switch value.
- `display_val` output W: value for the display.
- `result_valid` output 1: a result is held.
- `flags` output 4: {N, Z, C, V} of the held result.
- `seq_error` output 1: sticky flag for an illegal state-code sequence.

## Operation
- `trans` is sampled together with `estado` at the same rising edge; `estado` is the pre-transition state.
- Captures, applied only when `trans`=1:
  - `estado`=0: `op1 <= data_in`; clear `result_valid`, `flags` and `res`.
  - `estado`=1: `op2 <= data_in`.
  - `estado`=2: `opcode <= data_in[1:0]`; set internal `busy`.
  - `estado`=3: clear `result_valid`; the operands are kept.
- Opcodes:
  - 00: ADD, `op1+op2`. C = carry out. V = signed overflow.
  - 01: SUB, `op1-op2`. C = no-borrow, i.e. `op1 >= op2` unsigned. V = signed overflow.
  - 10: AND. C=0, V=0.
  - 11: OR. C=0, V=0.
  - All opcodes: N = `res[W-1]`, Z = (`res`==0).
- Result computation: the cycle after `busy` is set, load `res` and `flags` from the ALU, set `result_valid`=1, clear `busy`.
- `display_val` mux, registered:
  - `estado` 0 or 1: `data_in`.
  - `estado` 2: `{W-2 zeros, data_in[1:0]}`.
  - `estado` 3: `res`.
- `seq_error` monitor:
  - Tracks the previous `estado`.
  - Legal changes: none, or +1 modulo 4 (3 → 0 wraps).
  - Any other change sets `seq_error`. It stays set until `rst`.
  - A change of `estado` without `trans` on the previous cycle also sets `seq_error`.
- Reset values: `op1`, `op2`, `opcode`, `res`, `display_val`, `flags` = 0; `result_valid`, `seq_error`, `busy` = 0; previous-state register = 0.

## Timing
- Capture latency: register updated at the edge where `trans`=1.
- Result latency: `result_valid` rises exactly 2 edges after the opcode-capture edge (capture edge + 1 compute edge). It is therefore valid once the sequencer is in show_result.
- `display_val` follows `estado` and `data_in` with 1 cycle of latency.
- `trans` in state 3 arriving during the compute cycle (back-to-back): the compute still completes first. Clearing has priority on the next `trans`; the same-edge conflict resolves to clear.
- `trans` held high for several cycles: each cycle counts as a pulse. A held `trans` inherently steps the sequencer, so the monitor does not flag it.
- `rst` mid-compute: `busy` is dropped and no result appears.

## Structure
- Shared package `calc_pkg`:
  - sequencer state enum: WAIT_OP1=0, WAIT_OP2=1, WAIT_OP=2, SHOW_RESULT=3. Common to the sequencer and this block.
  - opcode enum: ADD, SUB, AND, OR.
  - flag bit index constants: N=3, Z=2, C=1, V=0.
- Sub-module `calc_alu`: purely combinational. Ports: `a`, `b`, `op`, `res`, `flags`; parameterized by `W`.

## Test plan
- Basic ADD: `data_in` 0x0005 / 0x0003 / op 00 with `trans` at estado 0,1,2 → `result_valid`=1 two edges later, `display_val`=0x0008 in estado 3, `flags`=0000.
- SUB negative: 0x0003 − 0x0005 → `res`=0xFFFE, N=1, Z=0, C=0, V=0.
- ADD overflow: 0x7FFF + 0x0001 → `res`=0x8000, N=1, V=1, C=0. Then 0xFFFF + 0x0001 → `res`=0, Z=1, C=1.
- Wrap and clear: `trans` at estado 3, then at estado 0 → `result_valid`=0 and `flags`=0. New `op1` captured; old `op2` still used if not recaptured.
- Illegal sequence: drive `estado` 0 → 2 → `seq_error`=1 one edge later and it stays 1 through legal steps. Assert `rst` → `seq_error`=0.
- Async reset mid-compute: assert `rst` between the opcode capture and the result edge → all outputs 0 immediately without a clock edge; `result_valid` never rises.
